fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory request/response bus between the fetch
//                unit (master) and instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. One outstanding memory request,
//                a one-entry hold buffer for words returning under stall,
//                and a drain state that swallows a response killed by flush.
//                Drives the IF/ID pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] npc,
    output logic      [31:0] pc,
    input  wire logic        stall,
    input  wire logic        flush,
    fetch_unit_if.master     imem,
    output logic      [31:0] instr,
    output logic      [31:0] instr_pc,
    output logic             instr_valid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic        w_deliver;
    logic [31:0] w_deliver_instr;
    logic [31:0] w_deliver_pc;

    // State register and datapath registers, asynchronously reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            hold_instr_q  <= 32'd0;
            hold_pc_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
        end
    end

    // Next-state, PC advance, hold-buffer capture and IF/ID update
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        instr_pc_d      = instr_pc_q;
        instr_valid_d   = instr_valid_q;
        hold_instr_d    = hold_instr_q;
        hold_pc_d       = hold_pc_q;
        w_deliver       = 1'b0;
        w_deliver_instr = imem.imem_rdata;
        w_deliver_pc    = pc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // A grant coinciding with flush is ignored: the request
                // is re-issued at the redirected address.
                if (!flush && imem.imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = imem.imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem.imem_rvalid) begin
                    if (stall) begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc_d    = pc_q;
                        state_d      = S_HOLD;
                    end else begin
                        w_deliver = 1'b1;
                        pc_d      = npc;
                        state_d   = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                w_deliver_instr = hold_instr_q;
                w_deliver_pc    = hold_pc_q;
                if (flush) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    w_deliver = 1'b1;
                    pc_d      = npc;
                    state_d   = S_REQ;
                end
            end
            S_DRAIN: begin
                // The killed response may land in the same cycle as a second
                // flush; it still completes the drain, else we would wait
                // forever for a response that is never coming.
                if (imem.imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect overrides any PC advance chosen above
        if (flush) begin
            pc_d = npc;
        end

        // IF/ID: flush bubbles, stall freezes, otherwise deliver or bubble
        if (flush) begin
            instr_valid_d = 1'b0;
        end else if (!stall) begin
            instr_valid_d = w_deliver;
            if (w_deliver) begin
                instr_d    = w_deliver_instr;
                instr_pc_d = w_deliver_pc;
            end
        end
    end

    assign imem.imem_req  = (state_q == S_REQ);
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_valid    = instr_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. The bench acts
//                as both the instruction memory and the next-PC stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    int checks;
    int errors;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc         (npc),
        .pc          (pc),
        .stall       (stall),
        .flush       (flush),
        .imem        (imem_bus.master),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_idle();
        imem_bus.imem_gnt    = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; npc = 32'h0;
        imem_bus.imem_rdata = 32'h0;
        mem_idle();
        step(); step();
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h3000); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, 32'h0); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h exp %h", instr_pc, 32'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_bus.imem_req); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", imem_bus.imem_req); end
        step();
        checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== 32'h3000) begin errors++; $display("FAIL first_addr got %h exp %h", imem_bus.imem_addr, 32'h3000); end
    endtask

    task automatic test_basic_fetch();
        imem_bus.imem_gnt = 1'b1; npc = 32'h3004;
        step();
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL wait_req got %b exp 0", imem_bus.imem_req); end
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h2408_0005;
        step();
        mem_idle();
        checks++; if (instr !== 32'h2408_0005) begin errors++; $display("FAIL basic_instr got %h exp %h", instr, 32'h2408_0005); end
        checks++; if (instr_pc !== 32'h3000) begin errors++; $display("FAIL basic_instr_pc got %h exp %h", instr_pc, 32'h3000); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", instr_valid); end
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL basic_pc got %h exp %h", pc, 32'h3004); end
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3004) begin errors++; $display("FAIL basic_next_req got %b/%h exp 1/%h", imem_bus.imem_req, imem_bus.imem_addr, 32'h3004); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [2];
        words[0] = 32'hA000_0001;
        words[1] = 32'hA000_0002;
        for (int k = 0; k < 2; k++) begin
            imem_bus.imem_gnt = 1'b1; npc = 32'h3008 + 32'(4 * k);
            step();
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble%0d got %b exp 0", k, instr_valid); end
            imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = words[k];
            step();
            mem_idle();
            checks++; if (instr !== words[k] || instr_pc !== 32'h3004 + 32'(4 * k) || instr_valid !== 1'b1) begin errors++;
                $display("FAIL b2b_deliver%0d got %h@%h v%b exp %h@%h v1", k, instr, instr_pc, instr_valid, words[k], 32'h3004 + 32'(4 * k)); end
            checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3008 + 32'(4 * k)) begin errors++;
                $display("FAIL b2b_req%0d got %b/%h exp 1/%h", k, imem_bus.imem_req, imem_bus.imem_addr, 32'h3008 + 32'(4 * k)); end
        end
    endtask

    task automatic test_stall_hold();
        // IF/ID holds A000_0002 @ 3008 valid; fetch at 300C under stall
        stall = 1'b1; imem_bus.imem_gnt = 1'b1; npc = 32'h3010;
        step();
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hB000_0001;
        step();
        mem_idle();
        for (int k = 0; k < 2; k++) begin
            checks++; if (instr !== 32'hA000_0002 || instr_pc !== 32'h3008 || instr_valid !== 1'b1) begin errors++;
                $display("FAIL stall_frozen%0d got %h@%h v%b exp a0000002@00003008 v1", k, instr, instr_pc, instr_valid); end
            checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_no_req%0d got %b exp 0", k, imem_bus.imem_req); end
            step();
        end
        stall = 1'b0;
        step();
        checks++; if (instr !== 32'hB000_0001 || instr_pc !== 32'h300C || instr_valid !== 1'b1) begin errors++;
            $display("FAIL hold_release got %h@%h v%b exp b0000001@0000300c v1", instr, instr_pc, instr_valid); end
        checks++; if (pc !== 32'h3010 || imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL hold_pc got %h req %b exp 00003010 req 1", pc, imem_bus.imem_req); end
    endtask

    task automatic test_flush_wait();
        imem_bus.imem_gnt = 1'b1; npc = 32'h3014;
        step();
        imem_bus.imem_gnt = 1'b0; flush = 1'b1; npc = 32'h3040;
        step();
        flush = 1'b0;
        checks++; if (instr_valid !== 1'b0 || pc !== 32'h3040 || imem_bus.imem_req !== 1'b0) begin errors++;
            $display("FAIL flush_wait got v%b pc %h req %b exp v0 pc 00003040 req 0", instr_valid, pc, imem_bus.imem_req); end
        step();
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        mem_idle();
        checks++; if (instr_valid !== 1'b0 || instr !== 32'hB000_0001) begin errors++;
            $display("FAIL drain_discard got %h v%b exp b0000001 v0", instr, instr_valid); end
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3040) begin errors++;
            $display("FAIL drain_restart got %b/%h exp 1/00003040", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_flush_rvalid_stall();
        imem_bus.imem_gnt = 1'b1; npc = 32'h3044;
        step();
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hC000_0001;
        stall = 1'b1; flush = 1'b1; npc = 32'h3080;
        step();
        mem_idle(); stall = 1'b0; flush = 1'b0;
        checks++; if (instr_valid !== 1'b0 || instr !== 32'hB000_0001 || pc !== 32'h3080) begin errors++;
            $display("FAIL flush_rvalid got %h v%b pc %h exp b0000001 v0 pc 00003080", instr, instr_valid, pc); end
        checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL flush_rvalid_req got %b exp 1", imem_bus.imem_req); end
    endtask

    task automatic test_flush_req();
        flush = 1'b1; imem_bus.imem_gnt = 1'b1; npc = 32'h3100;
        step();
        flush = 1'b0;
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3100) begin errors++;
            $display("FAIL flush_req got %b/%h exp 1/00003100", imem_bus.imem_req, imem_bus.imem_addr); end
        npc = 32'h3104;
        step();
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hD000_0001;
        step();
        mem_idle();
        checks++; if (instr !== 32'hD000_0001 || instr_pc !== 32'h3100 || instr_valid !== 1'b1) begin errors++;
            $display("FAIL flush_req_fetch got %h@%h v%b exp d0000001@00003100 v1", instr, instr_pc, instr_valid); end
    endtask

    task automatic test_reset_midflight();
        imem_bus.imem_gnt = 1'b1; npc = 32'h3108;
        step();
        mem_idle();
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h3000 || instr !== 32'h0 || instr_pc !== 32'h0 || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b0) begin errors++;
            $display("FAIL async_reset got pc %h instr %h ipc %h v%b req %b exp 00003000 0 0 0 0", pc, instr, instr_pc, instr_valid, imem_bus.imem_req); end
        step();
        rst_n = 1'b1;
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hEEEE_EEEE;
        step();
        step();
        mem_idle();
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL late_rvalid got %h v%b exp 0 v0", instr, instr_valid); end
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3000) begin errors++;
            $display("FAIL restart_addr got %b/%h exp 1/00003000", imem_bus.imem_req, imem_bus.imem_addr); end
        imem_bus.imem_gnt = 1'b1; npc = 32'h3004;
        step();
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hF000_0001;
        step();
        mem_idle();
        checks++; if (instr !== 32'hF000_0001 || instr_pc !== 32'h3000 || instr_valid !== 1'b1) begin errors++;
            $display("FAIL restart_fetch got %h@%h v%b exp f0000001@00003000 v1", instr, instr_pc, instr_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] top_pc;
        logic [31:0] seq_pc;
        top_pc = 32'hFFFF_FFFC;
        seq_pc = top_pc + 32'd4;
        flush = 1'b1; npc = top_pc;
        step();
        flush = 1'b0;
        checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h exp fffffffc", imem_bus.imem_addr); end
        imem_bus.imem_gnt = 1'b1; npc = seq_pc;
        step();
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h1111_1111;
        step();
        mem_idle();
        checks++; if (instr_pc !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_instr got %h v%b exp fffffffc v1", instr_pc, instr_valid); end
        checks++; if (imem_bus.imem_addr !== 32'h0 || imem_bus.imem_req !== 1'b1) begin errors++;
            $display("FAIL wrap_next got %h req %b exp 00000000 req 1", imem_bus.imem_addr, imem_bus.imem_req); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_stall_hold();
        test_flush_wait();
        test_flush_rvalid_stall();
        test_flush_req();
        test_reset_midflight();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
